mem_bus_responder: RTL and testbench

Memory-side responder for the 6502 core's microcoded request strobes. It accepts `mem_read_req`/`mem_write_req` from the control unit and runs the access against synchronous block RAM or a handshaked I/O page. It drives `rdy` low to stall the phase counter until the access completes, then returns read data. It sits between the control unit/datapath and the on-chip memories and peripherals of the DE10-Lite system.

---
 rtl/mem_bus_responder.sv | 147 ++++++++++++++
 tb/tb_mem_bus_responder.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_responder.sv
// mem_bus_responder: runs 6502 core memory requests against synchronous block
// RAM or a handshaked I/O page, holding rdy low until the access completes.
module mem_bus_responder #(
   parameter int unsigned RAM_WAIT = 1,
   parameter logic [3:0]  IO_PAGE  = 4'hD,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        mem_read_req,
   input  logic        mem_write_req,
   input  logic [15:0] addr,
   input  logic [7:0]  wdata,
   output logic [7:0]  rdata,
   output logic        rdy,
   output logic        mem_en,
   output logic        mem_we,
   output logic [15:0] mem_addr,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        io_req,
   output logic        io_we,
   output logic [11:0] io_addr,
   output logic [7:0]  io_wdata,
   input  logic [7:0]  io_rdata,
   input  logic        io_ack,
   input  logic        err_clr,
   output logic        bus_err,
   output logic [15:0] txn_count
);

   // One counter serves both the RAM wait and the I/O timeout.
   localparam int unsigned MAXC = (TIMEOUT > RAM_WAIT) ? TIMEOUT : RAM_WAIT;
   localparam int unsigned CW   = $clog2(MAXC + 1);

   typedef enum logic [2:0] {IDLE, ACCESS, WAIT, IO_WAIT, DONE} state_t;

   state_t        state;
   logic          is_wr;
   logic          is_io;
   logic [CW-1:0] cnt;
   logic          req;
   logic          err_set;

   assign req = mem_read_req | mem_write_req;

   // Conflicting strobes and I/O timeouts are the only error sources.
   assign err_set = (state == IDLE && mem_read_req && mem_write_req) ||
                    (state == IO_WAIT && !io_ack && cnt == '0);

   // rdy stalls the core in the same cycle a request shows up.
   always_comb begin
      rdy = 1'b0;
      if (reset_n) begin
         case (state)
            IDLE:    rdy = !req;
            DONE:    rdy = 1'b1;
            default: rdy = 1'b0;
         endcase
      end
   end

   // Access sequencer; all bus-side outputs are registered here.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         is_wr     <= 1'b0;
         is_io     <= 1'b0;
         cnt       <= '0;
         rdata     <= 8'h00;
         mem_en    <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 16'h0000;
         mem_wdata <= 8'h00;
         io_req    <= 1'b0;
         io_we     <= 1'b0;
         io_addr   <= 12'h000;
         io_wdata  <= 8'h00;
         txn_count <= 16'h0000;
      end else begin
         case (state)
            IDLE: begin
               if (req) begin
                  // A read+write collision is treated as a write.
                  is_wr <= mem_write_req;
                  if (addr[15:12] == IO_PAGE) begin
                     is_io    <= 1'b1;
                     io_addr  <= addr[11:0];
                     io_wdata <= wdata;
                  end else begin
                     is_io     <= 1'b0;
                     mem_addr  <= addr;
                     mem_wdata <= wdata;
                     mem_en    <= 1'b1;
                     mem_we    <= mem_write_req;
                  end
                  state <= ACCESS;
               end
            end
            ACCESS: begin
               if (is_io) begin
                  io_req <= 1'b1;
                  io_we  <= is_wr;
                  cnt    <= CW'(TIMEOUT - 1);
                  state  <= IO_WAIT;
               end else begin
                  mem_en <= 1'b0;
                  mem_we <= 1'b0;
                  cnt    <= CW'(RAM_WAIT - 1);
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (cnt == '0) begin
                  if (!is_wr) rdata <= mem_rdata;
                  txn_count <= txn_count + 16'd1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            IO_WAIT: begin
               // An ack on the last counted cycle still wins over the timeout.
               if (io_ack || cnt == '0) begin
                  if (!is_wr) rdata <= io_ack ? io_rdata : 8'hFF;
                  io_req    <= 1'b0;
                  io_we     <= 1'b0;
                  txn_count <= txn_count + 16'd1;
                  state     <= DONE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Sticky error flag; a new error beats a clear in the same cycle.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)     bus_err <= 1'b0;
      else if (err_set) bus_err <= 1'b1;
      else if (err_clr) bus_err <= 1'b0;
   end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: a vector table of complete
// transactions plus hand sequences for counter wrap and mid-access reset.
module tb_mem_bus_responder;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        mem_read_req, mem_write_req;
   logic [15:0] addr;
   logic [7:0]  wdata, rdata;
   logic        rdy, mem_en, mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        io_req, io_we;
   logic [11:0] io_addr;
   logic [7:0]  io_wdata, io_rdata;
   logic        io_ack, err_clr, bus_err;
   logic [15:0] txn_count;

   int          total = 0;
   int          pass  = 0;
   logic [15:0] cnt_m = 16'h0000;

   logic [7:0]  ram [0:65535];

   always #5 clk = ~clk;

   mem_bus_responder dut (
      .clk(clk), .reset_n(reset_n),
      .mem_read_req(mem_read_req), .mem_write_req(mem_write_req),
      .addr(addr), .wdata(wdata), .rdata(rdata), .rdy(rdy),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .io_req(io_req), .io_we(io_we), .io_addr(io_addr),
      .io_wdata(io_wdata), .io_rdata(io_rdata), .io_ack(io_ack),
      .err_clr(err_clr), .bus_err(bus_err), .txn_count(txn_count)
   );

   // Synchronous RAM with one-cycle read latency; preloaded while in reset.
   always @(posedge clk) begin
      if (!reset_n) begin
         ram[16'h0200] <= 8'h5A;
         ram[16'hC000] <= 8'h3C;
      end else if (mem_en) begin
         if (mem_we) ram[mem_addr] <= mem_wdata;
         else        mem_rdata     <= ram[mem_addr];
      end
   end

   typedef struct {
      logic        rd, wr, clr;
      logic [15:0] addr;
      logic [7:0]  wd, iod;
      int          ack;       // io_req cycles before ack; -1 = never
      logic [7:0]  e_rdata;
      logic        e_err;
      int          e_n;       // cycles with rdy low, request cycle included
      int          e_en, e_we, e_io;
   } vec_t;

   vec_t vecs [14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) pass++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   // Drives one request at a negedge and follows it to its DONE cycle.
   task automatic run(input string nm, input vec_t v);
      int n = 0, en = 0, we = 0, ioc = 0, k = 0;
      bit got = 0;
      @(negedge clk);
      mem_read_req  = v.rd;
      mem_write_req = v.wr;
      err_clr       = v.clr;
      addr          = v.addr;
      wdata         = v.wd;
      io_rdata      = v.iod;
      for (int c = 0; c < 64; c++) begin
         #1;
         if (rdy && c > 0) begin got = 1; break; end
         n++;
         if (mem_en) en++;
         if (mem_we) we++;
         if (io_req) ioc++;
         @(negedge clk);
         mem_read_req  = 1'b0;
         mem_write_req = 1'b0;
         err_clr       = 1'b0;
         if (io_req) k++;
         io_ack = (v.ack >= 0) && io_req && (k == v.ack + 1);
      end
      if (!got) begin
         chk({nm, " done_timeout"}, 32'd0, 32'd1);
      end else begin
         cnt_m++;
         chk({nm, " stall"},   n,         v.e_n);
         chk({nm, " rdata"},   rdata,     v.e_rdata);
         chk({nm, " bus_err"}, bus_err,   v.e_err);
         chk({nm, " count"},   txn_count, cnt_m);
         chk({nm, " en_cyc"},  en,        v.e_en);
         chk({nm, " we_cyc"},  we,        v.e_we);
         chk({nm, " io_cyc"},  ioc,       v.e_io);
         chk({nm, " io_req_done"}, io_req, 1'b0);
         if (v.addr[15:12] == 4'hD) begin
            chk({nm, " io_addr"}, io_addr, v.addr[11:0]);
            if (v.wr) chk({nm, " io_wdata"}, io_wdata, v.wd);
         end else begin
            chk({nm, " mem_addr"}, mem_addr, v.addr);
            if (v.wr) chk({nm, " mem_wdata"}, mem_wdata, v.wd);
         end
      end
   endtask

   initial begin
      vec_t w;
      reset_n = 1'b0; mem_read_req = 1'b0; mem_write_req = 1'b0;
      addr = 16'h0000; wdata = 8'h00; io_rdata = 8'h00; io_ack = 1'b0; err_clr = 1'b0;

      //          rd    wr    clr   addr       wd     iod    ack e_rdata e_err n  en we io
      vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h0200, 8'h00, 8'h00, -1, 8'h5A, 1'b0, 3, 1, 0, 0};
      vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h01FF, 8'hC3, 8'h00, -1, 8'h5A, 1'b0, 3, 1, 1, 0};
      vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h01FF, 8'h00, 8'h00, -1, 8'hC3, 1'b0, 3, 1, 0, 0};
      vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'hD010, 8'h00, 8'h81,  4, 8'h81, 1'b0, 7, 0, 0, 5};
      vecs[4]  = '{1'b0, 1'b1, 1'b0, 16'hD055, 8'h99, 8'h00,  0, 8'h81, 1'b0, 3, 0, 0, 1};
      vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'hD0FF, 8'h00, 8'h42, 15, 8'h42, 1'b0, 18, 0, 0, 16};
      vecs[6]  = '{1'b1, 1'b0, 1'b0, 16'hC000, 8'h00, 8'h00, -1, 8'h3C, 1'b0, 3, 1, 0, 0};
      vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'hCFFF, 8'hA5, 8'h00, -1, 8'h3C, 1'b0, 3, 1, 1, 0};
      vecs[8]  = '{1'b1, 1'b0, 1'b0, 16'hCFFF, 8'h00, 8'h00, -1, 8'hA5, 1'b0, 3, 1, 0, 0};
      vecs[9]  = '{1'b1, 1'b0, 1'b0, 16'hD020, 8'h00, 8'h77, -1, 8'hFF, 1'b1, 18, 0, 0, 16};
      vecs[10] = '{1'b1, 1'b0, 1'b1, 16'h0200, 8'h00, 8'h00, -1, 8'h5A, 1'b0, 3, 1, 0, 0};
      vecs[11] = '{1'b1, 1'b1, 1'b1, 16'h0300, 8'h11, 8'h00, -1, 8'h5A, 1'b1, 3, 1, 1, 0};
      vecs[12] = '{1'b1, 1'b0, 1'b0, 16'h0300, 8'h00, 8'h00, -1, 8'h11, 1'b1, 3, 1, 0, 0};
      vecs[13] = '{1'b1, 1'b0, 1'b1, 16'h0200, 8'h00, 8'h00, -1, 8'h5A, 1'b0, 3, 1, 0, 0};

      // Reset values
      @(negedge clk); @(negedge clk);
      #1;
      chk("rst rdy",       rdy,       1'b0);
      chk("rst txn_count", txn_count, 16'h0000);
      chk("rst bus_err",   bus_err,   1'b0);
      chk("rst mem_en",    mem_en,    1'b0);
      chk("rst io_req",    io_req,    1'b0);
      chk("rst rdata",     rdata,     8'h00);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("idle rdy", rdy, 1'b1);

      for (int i = 0; i < 14; i++) run($sformatf("v%0d", i), vecs[i]);

      // txn_count wrap: preset to FFFF, one colliding access wraps it and sets bus_err
      @(negedge clk);
      force dut.txn_count = 16'hFFFF;
      @(negedge clk);
      release dut.txn_count;
      cnt_m = 16'hFFFF;
      w = '{1'b1, 1'b1, 1'b0, 16'h0400, 8'h66, 8'h00, -1, 8'h5A, 1'b1, 3, 1, 1, 0};
      run("wrap", w);

      // Reset during WAIT abandons the access
      @(negedge clk);
      mem_read_req = 1'b1; addr = 16'h0200;
      @(negedge clk);            // ACCESS
      mem_read_req = 1'b0;
      @(negedge clk);            // WAIT
      chk("pre_rst mem_en", mem_en, 1'b0);
      reset_n = 1'b0;
      #1;
      chk("mid_rst rdy",       rdy,       1'b0);
      chk("mid_rst txn_count", txn_count, 16'h0000);
      chk("mid_rst bus_err",   bus_err,   1'b0);
      chk("mid_rst rdata",     rdata,     8'h00);
      chk("mid_rst mem_addr",  mem_addr,  16'h0000);
      chk("mid_rst mem_wdata", mem_wdata, 8'h00);
      chk("mid_rst io_addr",   io_addr,   12'h000);
      @(negedge clk);
      reset_n = 1'b1;
      #1 chk("post_rst idle rdy", rdy, 1'b1);
      cnt_m = 16'h0000;
      run("post_rst", vecs[0]);

      @(negedge clk);
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

endmodule
